rbm_vote_controller: RTL and testbench
======================================

RBM_VOTE_CONTROLLER -- requirements
Module: rbm_vote_controller

Interface
REQ-001 SHALL have parameter OUTPUT_DIM, default 10: number of class lines sampled per iteration.
REQ-002 SHALL have parameter COUNT_W, default 12: width of each per-class vote counter.
REQ-003 SHALL have parameter ITER_W, default 10: width of the iteration limit and the iteration counter.
REQ-004 SHALL have parameter MARGIN, default 8: early-stop lead threshold in votes (used only when REQ-026 applies).
REQ-005 SHALL have localparam WIN_W = max(1, ceil(log2(OUTPUT_DIM))).
REQ-006 SHALL have port clock, input, 1: the single clock; all logic on posedge.
REQ-007 SHALL have port reset, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port start, input, 1: begin a classification run.
REQ-009 SHALL have port iter_limit, input, ITER_W: number of sampling iterations, sampled when start is accepted.
REQ-010 SHALL have port sample_valid, input, 1: sampling engine presents one binary sample.
REQ-011 SHALL have port sample, input, OUTPUT_DIM: binary class sample, bit i = class i.
REQ-012 SHALL have port layer_reset, output, 1: registered reset to the RBM layer pipeline.
REQ-013 SHALL have port votes, output, OUTPUT_DIM*COUNT_W: packed counters, class i at bits [i*COUNT_W +: COUNT_W].
REQ-014 SHALL have port winner, output, WIN_W: index of the class with the most votes.
REQ-015 SHALL have port iterations, output, ITER_W: number of samples accumulated in the current run.
REQ-016 SHALL have port busy, output, 1: run in progress.
REQ-017 SHALL have port finish, output, 1: run complete and results valid.

Function
REQ-018 SHALL implement the FSM states IDLE, ARM, WAIT and DONE; busy=1 exactly in ARM and WAIT.
REQ-019 SHALL, on start=1 in IDLE or DONE: clear votes, iterations, winner and finish; latch iter_limit; go to DONE if the latched limit is 0, else to ARM; all of this on the next edge.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL drive layer_reset=1 in IDLE, ARM and DONE, and 0 only in WAIT, giving at least one reset cycle before every sample.
REQ-022 SHALL stay in ARM for exactly one cycle, then go to WAIT.
REQ-023 SHALL, in WAIT on sample_valid=1, in the same edge: increment each counter i whose sample[i]=1; increment iterations; go to DONE if iterations+1 equals the latched limit (or REQ-026 fires), else go to ARM.
REQ-024 SHALL saturate each vote counter at 2^COUNT_W-1 (no wrap); SHALL ignore sample_valid outside WAIT.
REQ-025 SHALL register winner on entry to DONE as the lowest index holding the maximum count; winner is 0 for an all-zero vote set; finish=1 throughout DONE until start is accepted or reset is asserted.

Configuration
REQ-026 SHALL, with macro RBM_VOTE_EARLY_STOP_EN defined, also go to DONE after an update once the maximum count minus the largest count among all other classes (computed on the post-update values) is at least MARGIN; without the macro, every run SHALL take exactly the latched number of iterations, and MARGIN SHALL be unused.

Reset
REQ-027 SHALL, while reset=0 at a clock edge, set: state=IDLE, votes=0, iterations=0, winner=0, busy=0, finish=0, layer_reset=1.
REQ-028 SHALL let reset override start and sample_valid in the same cycle; reset mid-run SHALL abandon the run and produce no finish.

Verification
REQ-029 SHALL cover reset: reset=0 for 2 cycles -> votes=0, iterations=0, winner=0, busy=0, finish=0, layer_reset=1.
REQ-030 SHALL cover a basic run: iter_limit=3, three samples 10'b0000000100 -> votes[2]=3, others 0, winner=2, iterations=3, finish=1, layer_reset=0 only in WAIT cycles.
REQ-031 SHALL cover tie-break: iter_limit=2, both samples 10'b0000100010 -> votes[1]=votes[5]=2, winner=1.
REQ-032 SHALL cover saturation: COUNT_W=2, iter_limit=5, sample 10'b0000000001 each time -> votes[0]=3, iterations=5.
REQ-033 SHALL cover early stop: MARGIN=4, iter_limit=30, sample 10'b0010000000 each time -> with the macro, finish after 4 samples (iterations=4, winner=7); without it, iterations=30.
REQ-034 SHALL cover boundaries: reset=0 in WAIT after 2 samples -> all cleared on the next edge; start with iter_limit=0 -> finish=1 on the next edge, votes=0.

Source files
------------

// File: rtl/rbm_vote_controller.sv
// RBM class-vote accumulator: samples class lines, counts votes, picks winner.
// Optional early stop on a vote lead of MARGIN: define RBM_VOTE_EARLY_STOP_EN.
module rbm_vote_controller #(
  parameter int OUTPUT_DIM = 10,
  parameter int COUNT_W    = 12,
  parameter int ITER_W     = 10,
  parameter int MARGIN     = 8,
  localparam int WIN_W     = (OUTPUT_DIM > 1) ? $clog2(OUTPUT_DIM) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ITER_W-1:0]             iter_limit,
  input  logic                          sample_valid,
  input  logic [OUTPUT_DIM-1:0]         sample,
  output logic                          layer_reset,
  output logic [OUTPUT_DIM*COUNT_W-1:0] votes,
  output logic [WIN_W-1:0]              winner,
  output logic [ITER_W-1:0]             iterations,
  output logic                          busy,
  output logic                          finish
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [COUNT_W-1:0]  cnt_q [OUTPUT_DIM];
  logic [COUNT_W-1:0]  cnt_d [OUTPUT_DIM];
  logic [ITER_W-1:0]   iter_q;
  logic [ITER_W-1:0]   iter_d;
  logic [ITER_W-1:0]   lim_q;
  logic [WIN_W-1:0]    win_q;
  logic                busy_q;
  logic                fin_q;
  logic                lr_q;

  logic [COUNT_W-1:0]  best_val;
  logic [WIN_W-1:0]    best_idx;
  logic                last_iter;
  logic                early_stop;

  // Post-update counts; only committed on an accepted sample.
  always_comb begin
    for (int i = 0; i < OUTPUT_DIM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sample[i] && (cnt_q[i] != {COUNT_W{1'b1}}))
        cnt_d[i] = cnt_q[i] + COUNT_W'(1);
    end
  end

  always_comb begin
    best_val = cnt_d[0];
    best_idx = '0;
    for (int i = 1; i < OUTPUT_DIM; i++) begin
      if (cnt_d[i] > best_val) begin
        best_val = cnt_d[i];
        best_idx = WIN_W'(i);
      end
    end
  end

`ifdef RBM_VOTE_EARLY_STOP_EN
  logic [COUNT_W-1:0] sec_val;
  logic [COUNT_W-1:0] lead;

  always_comb begin
    sec_val = '0;
    for (int i = 0; i < OUTPUT_DIM; i++) begin
      if ((WIN_W'(i) != best_idx) && (cnt_d[i] > sec_val))
        sec_val = cnt_d[i];
    end
  end

  assign lead       = best_val - sec_val;
  assign early_stop = (int'(lead) >= MARGIN);
`else
  assign early_stop = 1'b0;
`endif

  assign iter_d    = iter_q + ITER_W'(1);
  assign last_iter = (iter_d == lim_q);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < OUTPUT_DIM; i++)
        cnt_q[i] <= '0;
      iter_q  <= '0;
      lim_q   <= '0;
      win_q   <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      lr_q    <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int i = 0; i < OUTPUT_DIM; i++)
              cnt_q[i] <= '0;
            iter_q <= '0;
            win_q  <= '0;
            lim_q  <= iter_limit;
            lr_q   <= 1'b1;
            if (iter_limit == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              fin_q   <= 1'b1;
            end else begin
              state_q <= S_ARM;
              busy_q  <= 1'b1;
              fin_q   <= 1'b0;
            end
          end
        end
        S_ARM: begin
          state_q <= S_WAIT;
          lr_q    <= 1'b0;
        end
        S_WAIT: begin
          if (sample_valid) begin
            cnt_q  <= cnt_d;
            iter_q <= iter_d;
            lr_q   <= 1'b1;
            if (last_iter || early_stop) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              fin_q   <= 1'b1;
              win_q   <= best_idx;
            end else begin
              state_q <= S_ARM;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          fin_q   <= 1'b0;
          lr_q    <= 1'b1;
        end
      endcase
    end
  end

  for (genvar g = 0; g < OUTPUT_DIM; g++) begin : g_votes
    assign votes[g*COUNT_W +: COUNT_W] = cnt_q[g];
  end

  assign layer_reset = lr_q;
  assign winner      = win_q;
  assign iterations  = iter_q;
  assign busy        = busy_q;
  assign finish      = fin_q;

endmodule

// File: tb/tb_rbm_vote_controller.sv
// Randomized bench for rbm_vote_controller against a run-level vote model.
// Instance 0 uses 12-bit counters, instance 1 uses 2-bit counters.
module tb_rbm_vote_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic       st  [2];
  logic       sv  [2];
  logic [9:0] lim [2];
  logic [9:0] smp [2];
  logic       lr  [2];
  logic       b   [2];
  logic       f   [2];
  logic [3:0] w   [2];
  logic [9:0] it  [2];
  logic [119:0] vo0;
  logic [19:0]  vo1;

  rbm_vote_controller #(
    .OUTPUT_DIM(10), .COUNT_W(12), .ITER_W(10), .MARGIN(4)
  ) dut0 (
    .clock(clk), .reset(rst[0]), .start(st[0]),
    .iter_limit(lim[0]), .sample_valid(sv[0]), .sample(smp[0]),
    .layer_reset(lr[0]), .votes(vo0), .winner(w[0]),
    .iterations(it[0]), .busy(b[0]), .finish(f[0])
  );

  rbm_vote_controller #(
    .OUTPUT_DIM(10), .COUNT_W(2), .ITER_W(10), .MARGIN(4)
  ) dut1 (
    .clock(clk), .reset(rst[1]), .start(st[1]),
    .iter_limit(lim[1]), .sample_valid(sv[1]), .sample(smp[1]),
    .layer_reset(lr[1]), .votes(vo1), .winner(w[1]),
    .iterations(it[1]), .busy(b[1]), .finish(f[1])
  );

  int n_chk  = 0;
  int n_pass = 0;
  int mc [10];
  int mn;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic int getv(input int d, input int i);
    if (d == 0) return int'(vo0[i*12 +: 12]);
    return int'(vo1[i*2 +: 2]);
  endfunction

  function automatic int exp_win();
    int best = 0;
    for (int i = 1; i < 10; i++)
      if (mc[i] > mc[best]) best = i;
    return best;
  endfunction

  // Lead of the top class over the runner-up (0 on a tie for first).
  function automatic int lead();
    int top = 0;
    int sec = 0;
    bit seen = 0;
    for (int i = 0; i < 10; i++)
      if (mc[i] > top) top = mc[i];
    for (int i = 0; i < 10; i++) begin
      if (mc[i] == top && !seen) seen = 1;
      else if (mc[i] > sec) sec = mc[i];
    end
    return top - sec;
  endfunction

  task automatic check_idle(input int d, input string tag);
    for (int i = 0; i < 10; i++)
      chk($sformatf("%s d%0d vote%0d", tag, d, i), getv(d, i), 0);
    chk($sformatf("%s d%0d iter", tag, d), int'(it[d]), 0);
    chk($sformatf("%s d%0d winner", tag, d), int'(w[d]), 0);
    chk($sformatf("%s d%0d busy", tag, d), int'(b[d]), 0);
    chk($sformatf("%s d%0d finish", tag, d), int'(f[d]), 0);
    chk($sformatf("%s d%0d lreset", tag, d), int'(lr[d]), 1);
  endtask

  task automatic check_done(input int d, input string tag);
    for (int i = 0; i < 10; i++)
      chk($sformatf("%s d%0d vote%0d", tag, d, i), getv(d, i), mc[i]);
    chk($sformatf("%s d%0d iter", tag, d), int'(it[d]), mn);
    chk($sformatf("%s d%0d winner", tag, d), int'(w[d]), exp_win());
    chk($sformatf("%s d%0d busy", tag, d), int'(b[d]), 0);
    chk($sformatf("%s d%0d finish", tag, d), int'(f[d]), 1);
    chk($sformatf("%s d%0d lreset", tag, d), int'(lr[d]), 1);
  endtask

  // One classification run; abort>0 asserts reset in WAIT after that
  // many samples instead of completing.
  task automatic run(input int d, input int limit, input bit fixed,
                     input logic [9:0] fs, input int abort,
                     input string tag);
    int cmax = (d == 0) ? 4095 : 3;
    int fav  = $urandom_range(0, 9);
    bit done = 0;
    logic [9:0] s;
    for (int i = 0; i < 10; i++) mc[i] = 0;
    mn = 0;
    @(negedge clk);
    st[d]  = 1'b1;
    lim[d] = 10'(limit);
    @(negedge clk);
    st[d]  = 1'b0;
    lim[d] = 10'($urandom);
    if (limit == 0) begin
      check_done(d, tag);
      return;
    end
    while (!done) begin
      chk($sformatf("%s d%0d arm busy", tag, d), int'(b[d]), 1);
      chk($sformatf("%s d%0d arm lreset", tag, d), int'(lr[d]), 1);
      chk($sformatf("%s d%0d arm finish", tag, d), int'(f[d]), 0);
      chk($sformatf("%s d%0d arm iter", tag, d), int'(it[d]), mn);
      sv[d]  = 1'($urandom);
      smp[d] = 10'($urandom);
      st[d]  = 1'($urandom);
      @(negedge clk);
      sv[d] = 1'b0;
      st[d] = 1'b0;
      if (abort > 0 && mn == abort) begin
        rst[d] = 1'b0;
        st[d]  = 1'b1;
        sv[d]  = 1'b1;
        smp[d] = '1;
        lim[d] = 10'd0;
        @(negedge clk);
        rst[d] = 1'b1;
        st[d]  = 1'b0;
        sv[d]  = 1'b0;
        check_idle(d, {tag, " abort"});
        @(negedge clk);
        check_idle(d, {tag, " after"});
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        chk($sformatf("%s d%0d wait lreset", tag, d), int'(lr[d]), 0);
        chk($sformatf("%s d%0d wait busy", tag, d), int'(b[d]), 1);
        @(negedge clk);
      end
      chk($sformatf("%s d%0d wait lreset", tag, d), int'(lr[d]), 0);
      if (fixed) s = fs;
      else begin
        s = 10'($urandom) & 10'($urandom);
        if ($urandom_range(0, 1) == 1) s[fav] = 1'b1;
      end
      sv[d]  = 1'b1;
      smp[d] = s;
      for (int i = 0; i < 10; i++)
        if (s[i] && mc[i] < cmax) mc[i]++;
      mn++;
      @(negedge clk);
      sv[d] = 1'b0;
      done = (mn == limit);
`ifdef RBM_VOTE_EARLY_STOP_EN
      if (lead() >= 4) done = 1;
`endif
    end
    check_done(d, tag);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; st[d] = 1'b0; sv[d] = 1'b0;
      lim[d] = '0;   smp[d] = '0;
    end
    repeat (2) @(negedge clk);
    check_idle(0, "reset");
    check_idle(1, "reset");
    rst[0] = 1'b1;
    rst[1] = 1'b1;

    run(0, 3, 1, 10'b0000000100, 0, "basic");
    chk("basic vote2", getv(0, 2), 3);
    chk("basic winner", int'(w[0]), 2);
    run(0, 2, 1, 10'b0000100010, 0, "tie");
    chk("tie winner", int'(w[0]), 1);
    run(1, 5, 1, 10'b0000000001, 0, "sat");
    chk("sat vote0", getv(1, 0), 3);
    chk("sat iter", int'(it[1]), 5);
    run(0, 30, 1, 10'b0010000000, 0, "early");
`ifdef RBM_VOTE_EARLY_STOP_EN
    chk("early iter", int'(it[0]), 4);
    chk("early winner", int'(w[0]), 7);
`else
    chk("early iter", int'(it[0]), 30);
`endif
    run(0, 5, 1, 10'b0000010000, 2, "midreset");
    run(0, 0, 0, 10'b0, 0, "zero");
    run(1, 0, 0, 10'b0, 0, "zero");

    for (int r = 0; r < 24; r++)
      run(r % 2, $urandom_range(0, 12), 0, 10'b0,
          (r % 7 == 3) ? 1 : 0, $sformatf("rnd%0d", r));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
